// File: rtl/fp24_pkg.sv
// Shared fp24 definitions: format constants, the packed operand view and the
// operand class enumeration used by the FPU units and the iterative divider.
package fp24_pkg;

  localparam int WIDTH = 24;
  localparam int EXP_W = 8;
  localparam int MAN_W = 15;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [WIDTH-1:0] QNAN    = 24'h7FC000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp24_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of one fp24 magnitude (sign excluded) into its class
// and its significand with the implicit leading one restored.
module fp_classify
  import fp24_pkg::*;
#(
  parameter int EXP_W = fp24_pkg::EXP_W,
  parameter int MAN_W = fp24_pkg::MAN_W
) (
  input  logic [EXP_W+MAN_W-1:0] x,
  output fp_class_e              cls,
  output logic [MAN_W:0]         sig
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = x[EXP_W+MAN_W-1:MAN_W];
  assign man_f = x[MAN_W-1:0];
  assign sig   = {1'b1, man_f};

  // Denormals are flushed, so a zero exponent alone means zero.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0)
      cls = ZERO;
    else if (&exp_f)
      cls = (man_f != '0) ? NAN : INF;
  end

endmodule

// File: rtl/fp_div.sv
// Iterative fp24 divider (restoring, one quotient bit per cycle, truncating).
// Build option FP_DIV_EARLY_OUT_EN lets special operands skip DIVIDE/NORM.
module fp_div
  import fp24_pkg::*;
#(
  parameter int WIDTH = fp24_pkg::WIDTH,
  parameter int EXP_W = fp24_pkg::EXP_W,
  parameter int MAN_W = fp24_pkg::MAN_W,
  parameter int BIAS  = fp24_pkg::BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_dz,
  output logic             flag_nv
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int QW = MAN_W + 2;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_TOP = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] ONE_S   = {{(EXP_W+1){1'b0}}, 1'b1};

  // Normalize the raw quotient, truncate to MAN_W bits and saturate the exponent.
  function automatic logic [WIDTH-1:0] pack_norm(input logic s,
                                                 input logic signed [EXP_W+1:0] e,
                                                 input logic [QW-1:0] q);
    logic signed [EXP_W+1:0] e_n;
    logic [MAN_W-1:0]        m;
    if (q[QW-1]) begin
      e_n = e;
      m   = q[MAN_W:1];
    end else begin
      e_n = e - ONE_S;
      m   = q[MAN_W-1:0];
    end
    if (e_n >= EXP_TOP)
      pack_norm = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e_n[EXP_W+1] || e_n == '0)
      pack_norm = {s, {(WIDTH-1){1'b0}}};
    else
      pack_norm = {s, e_n[EXP_W-1:0], m};
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          special_r;

  logic                    sign_r;
  logic signed [EXP_W+1:0] exp_r;
  logic [MAN_W:0]          mb_r;
  logic [MAN_W+1:0]        rem_r;
  logic [QW-1:0]           quo_r;
  logic [WIDTH-1:0]        spec_res_r;

  fp_class_e      cls_a, cls_b;
  logic [MAN_W:0] sig_a, sig_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x   (a[WIDTH-2:0]),
    .cls (cls_a),
    .sig (sig_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x   (b[WIDTH-2:0]),
    .cls (cls_b),
    .sig (sig_b)
  );

  logic                    sign_in;
  logic signed [EXP_W+1:0] exp_in;
  logic                    nv_in, dz_in, special_in;
  logic [WIDTH-1:0]        spec_res_in;

  assign sign_in = a[WIDTH-1] ^ b[WIDTH-1];
  assign exp_in  = $signed({2'b00, a[WIDTH-2:MAN_W]}) - $signed({2'b00, b[WIDTH-2:MAN_W]}) + BIAS_S;

  always_comb begin
    nv_in       = (cls_a == NAN) || (cls_b == NAN) ||
                  (cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF);
    dz_in       = (cls_a == NORMAL) && (cls_b == ZERO);
    special_in  = (cls_a != NORMAL) || (cls_b != NORMAL);
    spec_res_in = {sign_in, {(WIDTH-1){1'b0}}};
    if (nv_in)
      spec_res_in = QNAN[WIDTH-1:0];
    else if (cls_a == INF || cls_b == ZERO)
      spec_res_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // Restoring step: the divisor fits below 2^(MAN_W+1), so the difference does too.
  logic             q_bit;
  logic [MAN_W:0]   diff;
  logic [MAN_W:0]   rem_sel;

  assign q_bit   = rem_r >= {1'b0, mb_r};
  assign diff    = rem_r[MAN_W:0] - mb_r;
  assign rem_sel = q_bit ? diff : rem_r[MAN_W:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      special_r <= 1'b0;
      result    <= '0;
      flag_dz   <= 1'b0;
      flag_nv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            flag_dz   <= dz_in;
            flag_nv   <= nv_in;
            special_r <= special_in;
            cnt       <= '0;
`ifdef FP_DIV_EARLY_OUT_EN
            if (special_in) begin
              result <= spec_res_in;
              state  <= DONE;
            end else begin
              state  <= DIVIDE;
            end
`else
            state     <= DIVIDE;
`endif
          end
        end
        DIVIDE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= NORM;
        end
        NORM: begin
          result <= special_r ? spec_res_r : pack_norm(sign_r, exp_r, quo_r);
          state  <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_r     <= sign_in;
      exp_r      <= exp_in;
      mb_r       <= sig_b;
      rem_r      <= {1'b0, sig_a};
      quo_r      <= '0;
      spec_res_r <= spec_res_in;
    end else if (state == DIVIDE) begin
      rem_r <= {rem_sel, 1'b0};
      quo_r <= {quo_r[QW-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: hand-computed fp24 quotients, flags, latency,
// output back-pressure, mid-operation reset and back-to-back issue.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        in_ready, out_valid, flag_dz, flag_nv;
  logic [23:0] result;

  int compared = 0;
  int mismatched = 0;

`ifdef FP_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 19;
`endif

  fp_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_dz   (flag_dz),
    .flag_nv   (flag_nv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait for out_valid; latency counts the accept cycle as 1.
  task automatic run_op(input logic [23:0] ta, input logic [23:0] tb, output int lat);
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [23:0] ta, input logic [23:0] tb,
                          input logic [23:0] exp_res, input logic exp_dz, input logic exp_nv,
                          input int exp_lat);
    int lat;
    run_op(ta, tb, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {8'h0, result}, {8'h0, exp_res});
    check({tag, "_dz"}, {31'h0, flag_dz}, {31'h0, exp_dz});
    check({tag, "_nv"}, {31'h0, flag_nv}, {31'h0, exp_nv});
    take();
  endtask

  initial begin
    int lat;
    logic seen;
    int last_take, last_acc, takes;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_result", {8'h0, result}, 32'h0);
    check("rst_dz", {31'h0, flag_dz}, 32'd0);
    check("rst_nv", {31'h0, flag_nv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("div6_2", 24'h40C000, 24'h400000, 24'h404000, 1'b0, 1'b0, 19);
    op_check("div1_3", 24'h3F8000, 24'h404000, 24'h3EAAAA, 1'b0, 1'b0, 19);

    // Back-pressure: result held, no new accept while the result waits.
    run_op(24'hC0C000, 24'h400000, lat);
    check("neg_lat", lat, 19);
    check("neg_res", {8'h0, result}, 32'h00C04000);
    @(negedge clk);
    a = 24'h3F8000;
    b = 24'h400000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", {8'h0, result}, 32'h00C04000);
      check("hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take();
    check("after_take_valid", {31'h0, out_valid}, 32'd0);
    check("after_take_ready", {31'h0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_in_valid", {31'h0, out_valid}, 32'd0);

    op_check("dz", 24'h3F8000, 24'h000000, 24'h7F8000, 1'b1, 1'b0, SPEC_LAT);
    op_check("zero_zero", 24'h000000, 24'h000000, 24'h7FC000, 1'b0, 1'b1, SPEC_LAT);
    op_check("inf_inf", 24'h7F8000, 24'hFF8000, 24'h7FC000, 1'b0, 1'b1, SPEC_LAT);
    op_check("neginf_fin", 24'hFF8000, 24'h400000, 24'hFF8000, 1'b0, 1'b0, SPEC_LAT);
    op_check("fin_inf", 24'hC00000, 24'h7F8000, 24'h800000, 1'b0, 1'b0, SPEC_LAT);
    op_check("ovf", 24'h7F0000, 24'h3E8000, 24'h7F8000, 1'b0, 1'b0, 19);
    op_check("unf", 24'h008000, 24'h7F0000, 24'h000000, 1'b0, 1'b0, 19);

    // Reset asserted during the 8th DIVIDE cycle.
    @(negedge clk);
    a = 24'h40C000;
    b = 24'h400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_ready", {31'h0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", {31'h0, seen}, 32'd0);
    check("midrst_ready_after", {31'h0, in_ready}, 32'd1);
    op_check("post_rst", 24'h40C000, 24'h400000, 24'h404000, 1'b0, 1'b0, 19);

    // Back-to-back with out_ready tied high, sampled at falling edges.
    @(negedge clk);
    a = 24'h40C000;
    b = 24'h400000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_take = -1;
    last_acc = -1;
    takes = 0;
    for (int i = 0; i < 100 && takes < 3; i++) begin
      if (out_valid && out_ready) begin
        takes++;
        check("b2b_res", {8'h0, result}, 32'h00404000);
        check("b2b_latency", i - last_acc, 19);
        last_take = i;
      end
      if (in_valid && in_ready) begin
        if (last_take >= 0) check("b2b_accept_gap", i, last_take + 1);
        last_acc = i;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_takes", takes, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
